vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 Parameter H_FP, default 40, horizontal front porch (pixels).
REQ-003 Parameter H_SYNC, default 48, hsync pulse width (pixels).
REQ-004 Parameter H_BP, default 40, horizontal back porch (pixels); H_TOTAL = 928.
REQ-005 Parameter V_ACTIVE, default 480, visible lines; V_FP 13, V_SYNC 3, V_BP 29 likewise parameters; V_TOTAL = 525.
REQ-006 Parameter SYNC_POL, default 0, asserted sync level (0 = active-low).
REQ-007 Parameter PIPE_DELAY, default 1, range 1-4, cycles from vga_h/vga_v to returned pixel_in.
REQ-008 clk  input  1  pixel clock; the only clock.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 test_mode  input  1  selects test pattern (see Configuration).
REQ-011 pixel_in  input  24  RGB from frame renderer, valid PIPE_DELAY cycles after coordinates.
REQ-012 vga_h  output  11  current horizontal count, 0..H_TOTAL-1.
REQ-013 vga_v  output  11  current vertical count, 0..V_TOTAL-1.
REQ-014 hsync, vsync  output  1 each  sync pulses, aligned with rgb_out.
REQ-015 de  output  1  data enable, aligned with rgb_out.
REQ-016 rgb_out  output  24  panel pixel, R[23:16] G[15:8] B[7:0].
REQ-017 frame_start  output  1  one-cycle pulse when vga_h=0 and vga_v=0 (undelayed).

Function
REQ-018 vga_h SHALL increment by 1 every clk; at H_TOTAL-1 it SHALL wrap to 0 on the next cycle.
REQ-019 vga_v SHALL increment only in the cycle vga_h wraps; at V_TOTAL-1 with vga_h wrapping, vga_v SHALL wrap to 0.
REQ-020 Raw active SHALL be (vga_h < H_ACTIVE) and (vga_v < V_ACTIVE).
REQ-021 Raw hsync SHALL be asserted for H_ACTIVE+H_FP <= vga_h < H_ACTIVE+H_FP+H_SYNC.
REQ-022 Raw vsync SHALL be asserted for V_ACTIVE+V_FP <= vga_v < V_ACTIVE+V_FP+V_SYNC, for whole lines.
REQ-023 Raw active, hsync, vsync SHALL pass through a shift pipeline of exactly PIPE_DELAY+1 registers so de/hsync/vsync align with registered rgb_out.
REQ-024 rgb_out SHALL be registered: pixel_in when delayed de is high, else 24'h000000.
REQ-025 hsync/vsync output level SHALL be SYNC_POL when asserted, ~SYNC_POL otherwise.
REQ-026 frame_start SHALL be combinational-free (registered), high exactly one cycle per frame, coincident with vga_h=0,vga_v=0.
REQ-027 All counter arithmetic SHALL be 11-bit unsigned; no intermediate overflow for totals up to 2047.

Reset
REQ-028 While reset is high at clk edge: vga_h=0, vga_v=0, all pipeline stages cleared, de=0, rgb_out=0, frame_start=0, hsync/vsync deasserted (~SYNC_POL).
REQ-029 Reset asserted mid-frame SHALL abort the frame; first cycle after release SHALL present vga_h=0,vga_v=0 and frame_start=1.
REQ-030 During the PIPE_DELAY+1 cycles after release, de SHALL stay 0 until the first active coordinate has traversed the pipeline.

Configuration
REQ-031 Macro VGA_TIMING_TEST_PATTERN_EN defined: when test_mode=1, rgb_out in active region SHALL be eight vertical bars of H_ACTIVE/8 pixels, order white, yellow, cyan, green, magenta, red, blue, black (each channel 8'hFF or 8'h00), computed from delayed vga_h.
REQ-032 Macro undefined: test_mode SHALL be ignored and no pattern logic synthesised; rgb_out follows REQ-024.

Verification
REQ-033 Reset 3 cycles, release -> cycle 0 vga_h=0,vga_v=0,frame_start=1; cycle 927 vga_h=927; cycle 928 vga_h=0,vga_v=1.
REQ-034 Run one full frame (928*525 cycles) -> exactly 525 hsync pulses of 48 cycles, one vsync of 3*928 cycles, 800*480 de-high cycles, frame_start period 487200.
REQ-035 PIPE_DELAY=1, pixel_in = {vga_h[7:0] delayed 1, 16'h0} -> rgb_out[23:16] equals 0 on first de cycle and 8'd1 next; rgb_out=0 whenever de=0.
REQ-036 Assert reset at vga_h=400,vga_v=200 for 1 cycle -> next cycle counters 0/0, frame_start=1, de=0 for 2 cycles.
REQ-037 With VGA_TIMING_TEST_PATTERN_EN, test_mode=1 -> rgb_out=24'hFFFFFF at active x=0..99, 24'hFFFF00 at x=100, 24'h000000 at x=799; without macro rgb_out equals pixel_in.
REQ-038 SYNC_POL=1 -> hsync high only inside sync window, low at reset.

Source files
------------

// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel/line counters, delay-matched sync/DE and registered RGB.
// Optional colour-bar generator is compiled in with `define VGA_TIMING_TEST_PATTERN_EN.
module vga_timing #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 40,
    parameter int H_SYNC     = 48,
    parameter int H_BP       = 40,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 13,
    parameter int V_SYNC     = 3,
    parameter int V_BP       = 29,
    parameter int SYNC_POL   = 0,
    parameter int PIPE_DELAY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        test_mode,
    input  logic [23:0] pixel_in,
    output logic [10:0] vga_h,
    output logic [10:0] vga_v,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [23:0] rgb_out,
    output logic        frame_start
);

    localparam logic [10:0] H_TOTAL  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [10:0] V_TOTAL  = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        POL      = (SYNC_POL != 0) ? 1'b1 : 1'b0;
    localparam int          DEPTH    = PIPE_DELAY + 1;

    logic [10:0] r_h, r_v;
    logic [10:0] w_h_nxt, w_v_nxt;
    logic        r_run, r_fs;
    logic        w_act, w_hs, w_vs;
    logic [DEPTH-1:0] r_act_p, r_hs_p, r_vs_p;
    logic [23:0] w_pix, w_rgb_nxt, r_rgb;

    // r_run holds the counters at 0/0 for the first cycle after reset so that
    // cycle is the frame-start cycle the panel sees.
    always_comb begin
        w_h_nxt = r_h;
        w_v_nxt = r_v;
        if (r_run) begin
            if (r_h == H_TOTAL - 11'd1) begin
                w_h_nxt = 11'd0;
                w_v_nxt = (r_v == V_TOTAL - 11'd1) ? 11'd0 : r_v + 11'd1;
            end else begin
                w_h_nxt = r_h + 11'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_h   <= 11'd0;
            r_v   <= 11'd0;
            r_run <= 1'b0;
            r_fs  <= 1'b0;
        end else begin
            r_h   <= w_h_nxt;
            r_v   <= w_v_nxt;
            r_run <= 1'b1;
            r_fs  <= (w_h_nxt == 11'd0) && (w_v_nxt == 11'd0);
        end
    end

    assign w_act = r_run && (r_h < H_ACT) && (r_v < V_ACT);
    assign w_hs  = r_run && (r_h >= HS_START) && (r_h < HS_END);
    assign w_vs  = r_run && (r_v >= VS_START) && (r_v < VS_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_act_p <= '0;
            r_hs_p  <= '0;
            r_vs_p  <= '0;
        end else begin
            r_act_p <= {r_act_p[DEPTH-2:0], w_act};
            r_hs_p  <= {r_hs_p[DEPTH-2:0], w_hs};
            r_vs_p  <= {r_vs_p[DEPTH-2:0], w_vs};
        end
    end

`ifdef VGA_TIMING_TEST_PATTERN_EN
    localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

    logic [10:0] r_hd_p [PIPE_DELAY];

    // Bar index bits map directly to channel enables: white..black ordering.
    function automatic logic [23:0] bar_color(input logic [10:0] x);
        logic [2:0] idx;
        idx = 3'(x / BAR_W);
        return {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}};
    endfunction

    always_ff @(posedge clk) begin
        r_hd_p[0] <= r_h;
        for (int i = 1; i < PIPE_DELAY; i++) begin
            r_hd_p[i] <= r_hd_p[i-1];
        end
    end

    assign w_pix = test_mode ? bar_color(r_hd_p[PIPE_DELAY-1]) : pixel_in;
`else
    logic w_unused_test_mode;
    assign w_unused_test_mode = test_mode;
    assign w_pix = pixel_in;
`endif

    // Stage PIPE_DELAY-1 marks the coordinate whose pixel is on pixel_in now.
    assign w_rgb_nxt = r_act_p[DEPTH-2] ? w_pix : 24'h000000;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rgb <= 24'h000000;
        end else begin
            r_rgb <= w_rgb_nxt;
        end
    end

    assign vga_h       = r_h;
    assign vga_v       = r_v;
    assign frame_start = r_fs;
    assign de          = r_act_p[DEPTH-1];
    assign hsync       = r_hs_p[DEPTH-1] ? POL : ~POL;
    assign vsync       = r_vs_p[DEPTH-1] ? POL : ~POL;
    assign rgb_out     = r_rgb;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: default 800x480 instance (A) plus a tiny 16x6 instance (B, SYNC_POL=1, PIPE_DELAY=2).
module tb_vga_timing;

    logic        clk = 1'b0;
    logic        rst_a, rst_b, tmode;
    logic [23:0] pix_a = 24'h0;
    logic [23:0] pix_b = 24'h5A5A5A;
    logic [10:0] h_a, v_a, h_b, v_b;
    logic        hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;
    logic [23:0] rgb_a, rgb_b;
    logic [7:0]  prev_h = 8'h0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    vga_timing u_dut_a (
        .clk(clk), .reset(rst_a), .test_mode(tmode), .pixel_in(pix_a),
        .vga_h(h_a), .vga_v(v_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
        .rgb_out(rgb_a), .frame_start(fs_a)
    );

    vga_timing #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1), .PIPE_DELAY(2)
    ) u_dut_b (
        .clk(clk), .reset(rst_b), .test_mode(tmode), .pixel_in(pix_b),
        .vga_h(h_b), .vga_v(v_b), .hsync(hs_b), .vsync(vs_b), .de(de_b),
        .rgb_out(rgb_b), .frame_start(fs_b)
    );

    // Renderer model for A: returns the x coordinate of one cycle earlier in red.
    initial begin
        forever begin
            @(negedge clk);
            pix_a  = {prev_h, 16'h0};
            prev_h = h_a[7:0];
        end
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; tmode = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (h_a !== 11'd0 || v_a !== 11'd0) begin failures++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", h_a, v_a); end
        checks++; if (fs_a !== 1'b0 || de_a !== 1'b0) begin failures++; $display("FAIL rst_fs_de got=%b%b exp=00", fs_a, de_a); end
        checks++; if (rgb_a !== 24'h0) begin failures++; $display("FAIL rst_rgb got=%h exp=000000", rgb_a); end
        checks++; if (hs_a !== 1'b1 || vs_a !== 1'b1) begin failures++; $display("FAIL rst_sync_lo got=%b%b exp=11", hs_a, vs_a); end
        checks++; if (hs_b !== 1'b0 || vs_b !== 1'b0) begin failures++; $display("FAIL rst_sync_hi got=%b%b exp=00", hs_b, vs_b); end
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);
        cyc = 0;
        checks++; if (h_a !== 11'd0 || v_a !== 11'd0 || fs_a !== 1'b1) begin failures++; $display("FAIL cycle0 got=h%0d v%0d fs%b exp=h0 v0 fs1", h_a, v_a, fs_a); end
        checks++; if (de_a !== 1'b0) begin failures++; $display("FAIL cycle0_de got=%b exp=0", de_a); end
    endtask

    task automatic test_pixel_pipe();
        tick();
        checks++; if (de_a !== 1'b0 || fs_a !== 1'b0 || h_a !== 11'd1) begin failures++; $display("FAIL cycle1 got=de%b fs%b h%0d exp=de0 fs0 h1", de_a, fs_a, h_a); end
        tick();
        checks++; if (de_a !== 1'b1 || rgb_a !== 24'h000000) begin failures++; $display("FAIL first_de got=de%b rgb%h exp=de1 rgb000000", de_a, rgb_a); end
        tick();
        checks++; if (de_a !== 1'b1 || rgb_a !== 24'h010000) begin failures++; $display("FAIL second_de got=de%b rgb%h exp=de1 rgb010000", de_a, rgb_a); end
    endtask

    task automatic test_line();
        logic        ede, ehs;
        logic [23:0] ergb;
        int bad_h = 0, bad_de = 0, bad_hs = 0, bad_rgb = 0, bad_vf = 0, hs_cnt = 0;
        while (cyc < 927) begin
            tick();
            ede  = (cyc >= 2) && (cyc <= 801);
            ehs  = !((cyc >= 842) && (cyc < 890));
            ergb = ede ? {8'(cyc - 2), 16'h0} : 24'h0;
            if (h_a !== 11'(cyc)) bad_h++;
            if (de_a !== ede) bad_de++;
            if (hs_a !== ehs) bad_hs++;
            if (rgb_a !== ergb) bad_rgb++;
            if (vs_a !== 1'b1 || fs_a !== 1'b0 || v_a !== 11'd0) bad_vf++;
            if (hs_a === 1'b0) hs_cnt++;
        end
        checks++; if (bad_h !== 0) begin failures++; $display("FAIL line_hcount bad=%0d exp=0", bad_h); end
        checks++; if (bad_de !== 0) begin failures++; $display("FAIL line_de bad=%0d exp=0", bad_de); end
        checks++; if (bad_hs !== 0) begin failures++; $display("FAIL line_hsync bad=%0d exp=0", bad_hs); end
        checks++; if (bad_rgb !== 0) begin failures++; $display("FAIL line_rgb bad=%0d exp=0", bad_rgb); end
        checks++; if (bad_vf !== 0) begin failures++; $display("FAIL line_vsync_fs bad=%0d exp=0", bad_vf); end
        checks++; if (hs_cnt !== 48) begin failures++; $display("FAIL hsync_width got=%0d exp=48", hs_cnt); end
        checks++; if (h_a !== 11'd927 || v_a !== 11'd0) begin failures++; $display("FAIL cycle927 got=%0d/%0d exp=927/0", h_a, v_a); end
        tick();
        checks++; if (h_a !== 11'd0 || v_a !== 11'd1 || fs_a !== 1'b0) begin failures++; $display("FAIL cycle928 got=h%0d v%0d fs%b exp=h0 v1 fs0", h_a, v_a, fs_a); end
    endtask

    task automatic test_test_mode();
        int          xs [5] = '{0, 99, 100, 250, 799};
        logic [23:0] exp_rgb;
        tmode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            while (cyc < 930 + xs[i]) tick();
`ifdef VGA_TIMING_TEST_PATTERN_EN
            case (i)
                0, 1:    exp_rgb = 24'hFFFFFF;
                2:       exp_rgb = 24'hFFFF00;
                3:       exp_rgb = 24'h00FFFF;
                default: exp_rgb = 24'h000000;
            endcase
`else
            exp_rgb = {8'(xs[i]), 16'h0};
`endif
            checks++; if (de_a !== 1'b1 || rgb_a !== exp_rgb) begin failures++; $display("FAIL tmode_x%0d got=de%b rgb%h exp=de1 rgb%h", xs[i], de_a, rgb_a, exp_rgb); end
        end
        tick();
        checks++; if (de_a !== 1'b0 || rgb_a !== 24'h0) begin failures++; $display("FAIL tmode_blank got=de%b rgb%h exp=de0 rgb000000", de_a, rgb_a); end
        tmode = 1'b0;
    endtask

    task automatic test_mid_reset();
        while (cyc < 2256) tick();
        checks++; if (h_a !== 11'd400 || v_a !== 11'd2 || de_a !== 1'b1) begin failures++; $display("FAIL pre_reset got=h%0d v%0d de%b exp=h400 v2 de1", h_a, v_a, de_a); end
        rst_a = 1'b1;
        tick();
        checks++; if (h_a !== 11'd0 || v_a !== 11'd0 || fs_a !== 1'b0 || de_a !== 1'b0 || rgb_a !== 24'h0) begin failures++; $display("FAIL in_reset got=h%0d v%0d fs%b de%b rgb%h exp=0 0 0 0 000000", h_a, v_a, fs_a, de_a, rgb_a); end
        rst_a = 1'b0;
        tick();
        checks++; if (h_a !== 11'd0 || v_a !== 11'd0 || fs_a !== 1'b1 || de_a !== 1'b0) begin failures++; $display("FAIL post_reset0 got=h%0d v%0d fs%b de%b exp=h0 v0 fs1 de0", h_a, v_a, fs_a, de_a); end
        tick();
        checks++; if (h_a !== 11'd1 || de_a !== 1'b0) begin failures++; $display("FAIL post_reset1 got=h%0d de%b exp=h1 de0", h_a, de_a); end
        tick();
        checks++; if (de_a !== 1'b1 || rgb_a !== 24'h0) begin failures++; $display("FAIL post_reset2 got=de%b rgb%h exp=de1 rgb000000", de_a, rgb_a); end
    endtask

    task automatic test_small_frame();
        bit   found = 0;
        int   m, hm, vm, bad = 0, bad_cnt = 0, hs_edges = 0, hs_hi = 0, vs_hi = 0, de_hi = 0, fs_cnt = 0;
        logic ede, ehs, evs, prev_hs = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            tick();
            if (fs_b === 1'b1) found = 1;
        end
        checks++; if (!found) begin failures++; $display("FAIL small_fs_timeout got=none exp=pulse"); return; end
        for (int n = 0; n < 240; n++) begin
            if (n > 0) tick();
            m   = (n + 237) % 240;
            hm  = m % 24;
            vm  = m / 24;
            ede = (hm < 16) && (vm < 6);
            ehs = (hm >= 18) && (hm < 21);
            evs = (vm >= 7) && (vm < 9);
            if (h_b !== 11'(n % 24) || v_b !== 11'(n / 24)) bad_cnt++;
            if (de_b !== ede || hs_b !== ehs || vs_b !== evs || fs_b !== (n == 0)) bad++;
            if (hs_b === 1'b1 && prev_hs === 1'b0) hs_edges++;
            prev_hs = hs_b;
            if (hs_b === 1'b1) hs_hi++;
            if (vs_b === 1'b1) vs_hi++;
            if (de_b === 1'b1) de_hi++;
            if (fs_b === 1'b1) fs_cnt++;
        end
        checks++; if (bad_cnt !== 0) begin failures++; $display("FAIL small_counters bad=%0d exp=0", bad_cnt); end
        checks++; if (bad !== 0) begin failures++; $display("FAIL small_align bad=%0d exp=0", bad); end
        checks++; if (hs_edges !== 10 || hs_hi !== 30) begin failures++; $display("FAIL small_hsync got=%0d/%0d exp=10/30", hs_edges, hs_hi); end
        checks++; if (vs_hi !== 48) begin failures++; $display("FAIL small_vsync got=%0d exp=48", vs_hi); end
        checks++; if (de_hi !== 96) begin failures++; $display("FAIL small_de got=%0d exp=96", de_hi); end
        checks++; if (fs_cnt !== 1) begin failures++; $display("FAIL small_fs_count got=%0d exp=1", fs_cnt); end
        tick();
        checks++; if (fs_b !== 1'b1) begin failures++; $display("FAIL small_fs_period got=%b exp=1", fs_b); end
        checks++; if (rgb_b !== 24'h0 && de_b === 1'b0) begin failures++; $display("FAIL small_rgb_blank got=%h exp=000000", rgb_b); end
    endtask

    initial begin
        test_reset();
        test_pixel_pipe();
        test_line();
        test_test_mode();
        test_mid_reset();
        test_small_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
